// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-FIFO round-robin arbiter for the register file write port.
// Define WB_ARB_STATS_EN to add saturating grant/stall counters.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data,
  output logic              busy
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt_a,
  output logic [15:0]       grant_cnt_b,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  logic [EW-1:0] r_mem_a [DEPTH];
  logic [EW-1:0] r_mem_b [DEPTH];
  logic [PW-1:0] r_wp_a, r_rp_a, r_wp_b, r_rp_b;
  logic          r_last_b, r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic w_empty_a, w_empty_b, w_full_a, w_full_b;
  logic w_push_a, w_push_b, w_gnt_a, w_gnt_b, w_gnt;
  logic [EW-1:0] w_head;
  logic [ADDR_W-1:0] w_head_rd;
  // Full when the pointers differ only in the wrap bit.
  assign w_empty_a = r_wp_a == r_rp_a;
  assign w_empty_b = r_wp_b == r_rp_b;
  assign w_full_a  = (r_wp_a ^ r_rp_a) == {1'b1, {(PW-1){1'b0}}};
  assign w_full_b  = (r_wp_b ^ r_rp_b) == {1'b1, {(PW-1){1'b0}}};
  assign a_ready   = !w_full_a;
  assign b_ready   = !w_full_b;
  assign w_push_a  = a_valid && !w_full_a;
  assign w_push_b  = b_valid && !w_full_b;
  assign w_gnt_a   = !w_empty_a && (w_empty_b || r_last_b);
  assign w_gnt_b   = !w_empty_b && !w_gnt_a;
  assign w_gnt     = w_gnt_a || w_gnt_b;
  assign w_head    = w_gnt_a ? r_mem_a[r_rp_a[PW-2:0]] : r_mem_b[r_rp_b[PW-2:0]];
  assign w_head_rd = w_head[EW-1:DATA_W];
  assign regWrite  = r_we;
  assign rd        = r_rd;
  assign data      = r_data;
  assign busy      = !w_empty_a || !w_empty_b || r_we;
  always_ff @(posedge clk) begin
    if (w_push_a) r_mem_a[r_wp_a[PW-2:0]] <= {a_rd, a_data};
    if (w_push_b) r_mem_b[r_wp_b[PW-2:0]] <= {b_rd, b_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp_a   <= '0;
      r_rp_a   <= '0;
      r_wp_b   <= '0;
      r_rp_b   <= '0;
      r_last_b <= 1'b1;
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
    end else begin
      if (w_push_a) r_wp_a <= r_wp_a + 1'b1;
      if (w_push_b) r_wp_b <= r_wp_b + 1'b1;
      if (w_gnt_a) r_rp_a <= r_rp_a + 1'b1;
      if (w_gnt_b) r_rp_b <= r_rp_b + 1'b1;
      if (w_gnt) begin
        r_rd     <= w_head_rd;
        r_data   <= w_head[DATA_W-1:0];
        r_last_b <= w_gnt_b;
      end
      r_we <= w_gnt && (w_head_rd != '0);
    end
  end
`ifdef WB_ARB_STATS_EN
  logic w_stall;
  assign w_stall = (a_valid && w_full_a) || (b_valid && w_full_b);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
      stall_cnt   <= '0;
    end else begin
      if (w_gnt_a && grant_cnt_a != 16'hFFFF) grant_cnt_a <= grant_cnt_a + 1'b1;
      if (w_gnt_b && grant_cnt_b != 16'hFFFF) grant_cnt_b <= grant_cnt_b + 1'b1;
      if (w_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        regWrite, busy;
  logic [4:0]  rd;
  logic [31:0] data;
`ifdef WB_ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b, stall_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int got_rd [16];
  int got_dt [16];
  int n;
  int ia, ib;
  logic acc_a, acc_b;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .regWrite(regWrite), .rd(rd), .data(data), .busy(busy)
`ifdef WB_ARB_STATS_EN
    , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    a_valid = 1'b1;
    a_rd = 5'd3;
    a_data = 32'h55;
    tick();
    tick();
    chk("rst_regWrite", regWrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    a_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    ia = 0; ib = 0; n = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      a_valid = ia < 3;
      a_rd = 5'(ia + 1);
      a_data = 32'(ia + 1) * 32'h11;
      b_valid = ib < 3;
      b_rd = 5'(ib + 11);
      b_data = 32'(ib + 11) * 32'h11;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      if (cyc == 2) chk("tie_b_full", b_ready, 0);
      if (regWrite && n < 16) begin
        got_rd[n] = int'(rd);
        got_dt[n] = int'(data);
        n++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("tie_count", n, 6);
    chk("tie_rd0", got_rd[0], 1);
    chk("tie_rd1", got_rd[1], 11);
    chk("tie_rd2", got_rd[2], 2);
    chk("tie_rd3", got_rd[3], 12);
    chk("tie_rd4", got_rd[4], 3);
    chk("tie_rd5", got_rd[5], 13);
    chk("tie_data3", got_dt[3], 12 * 17);
`ifdef WB_ARB_STATS_EN
    chk("stat_gnt_a", grant_cnt_a, 3);
    chk("stat_gnt_b", grant_cnt_b, 3);
    chk("stat_stall", stall_cnt, 1);
`endif
    chk("tie_idle", busy, 0);

    a_valid = 1'b1;
    a_rd = 5'd5;
    a_data = 32'hDEADBEEF;
    tick();
    a_valid = 1'b0;
    chk("single_we_e1", regWrite, 0);
    chk("single_busy_e1", busy, 1);
    tick();
    chk("single_we_e2", regWrite, 1);
    chk("single_rd_e2", rd, 5);
    chk("single_data_e2", data, 32'hDEADBEEF);
    tick();
    chk("single_we_e3", regWrite, 0);
    chk("single_busy_e3", busy, 0);
    chk("single_rd_hold", rd, 5);

    a_valid = 1'b1;
    a_rd = 5'd0;
    a_data = 32'h1234;
    tick();
    a_rd = 5'd4;
    a_data = 32'h44;
    b_valid = 1'b1;
    b_rd = 5'd9;
    b_data = 32'h99;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("x0_no_we", regWrite, 0);
    chk("x0_busy", busy, 1);
    tick();
    chk("x0_then_b_we", regWrite, 1);
    chk("x0_then_b_rd", rd, 9);
    chk("x0_then_b_data", data, 32'h99);
    tick();
    chk("x0_then_a_rd", rd, 4);
    tick();
    chk("x0_idle", busy, 0);

    n = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_valid = cyc < 5;
      a_rd = 5'(20 + cyc);
      a_data = 32'(cyc);
      if (cyc < 5) chk("stream_a_ready", a_ready, 1);
      tick();
      if (regWrite && n < 16) begin
        got_rd[n] = int'(rd);
        n++;
      end
    end
    a_valid = 1'b0;
    chk("stream_count", n, 5);
    for (int k = 0; k < 5; k++) chk("stream_rd", got_rd[k], 20 + k);

    a_valid = 1'b1;
    b_valid = 1'b1;
    a_rd = 5'd1;
    b_rd = 5'd2;
    tick();
    tick();
    tick();
    chk("pre_rst_we", regWrite, 1);
    chk("pre_rst_busy", busy, 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_we", regWrite, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    a_valid = 1'b1;
    a_rd = 5'd7;
    a_data = 32'h77;
    tick();
    a_valid = 1'b0;
    chk("after_rst_we_e1", regWrite, 0);
    tick();
    chk("after_rst_we_e2", regWrite, 1);
    chk("after_rst_rd_e2", rd, 7);
    tick();
    chk("after_rst_we_e3", regWrite, 0);
    chk("after_rst_busy", busy, 0);

    do_reset();
    tick();
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: A (ALU result path) and B (load/secondary path). Each requester pushes writes through a valid/ready handshake into a private in-order FIFO. A round-robin arbiter pops one head per cycle and drives registered `regWrite`/`rd`/`data` straight into the register file write port. Writes to x0 are consumed without asserting `regWrite`.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width
- `DEPTH`, 2, per-requester FIFO depth; power of two, ≥2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  requester A has a write
- `a_ready`  out  1  A FIFO not full
- `a_rd`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write data
- `b_valid`, `b_ready`, `b_rd`, `b_data`: same as A, for requester B
- `regWrite`  out  1  write enable to the register file (registered)
- `rd`  out  ADDR_W  write register index (registered)
- `data`  out  DATA_W  write data (registered)
- `busy`  out  1  high if either FIFO is non-empty or `regWrite` is high

## Operation
- **Accept:** A write is accepted on an edge where `x_valid && x_ready`, and is pushed to FIFO x.
- **Ready:** `x_ready = !full_x`, with no bypass. A full FIFO refuses a push even on a cycle it pops.
- **Arbitration:**
  - Exactly one head is popped per cycle when any FIFO is non-empty.
  - Only one head valid: that head is granted.
  - Both heads valid: the requester not granted last is granted.
  - `last_grant` resets to B, so A wins the first tie.
- **Grant of entry (r, d):**
  - Next cycle: `rd<=r`, `data<=d`, `regWrite<=(r!=0)`.
  - With no grant: `regWrite<=0`, and `rd`/`data` hold their last values.
  - An x0 grant still pops the entry and still updates `last_grant`.
- **Ordering:**
  - Writes from one requester are applied in acceptance order.
  - Between A and B there is no ordering guarantee. For the same `rd`, the later-granted write is final.
- **Pointers:** FIFO pointers are ADDR-free counters of log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full: pointers differ only in MSB
  - empty: pointers equal
- **Simultaneous events:** Push and pop on the same non-full FIFO in the same cycle are both performed, and occupancy is unchanged.
- **Reset:** Reset is asynchronous and takes effect mid-operation. All FIFO contents are discarded and every pending write is lost.
  - Reset values: `regWrite=0`, `rd=0`, `data=0`, `busy=0`, `last_grant=B`, FIFOs empty.
  - `a_ready`/`b_ready` read 1 in reset, but no push occurs while `rst_n=0`.

## Timing
- Accept at edge N → entry at FIFO head during cycle N+1 → granted at edge N+1 → `regWrite` high during cycle N+1..N+2 → register file writes at edge N+2.
- Minimum latency is 2 edges from accept to the register file update.
- Sustained throughput is 1 write/cycle total. Under saturation each requester gets 1 write per 2 cycles.
- `x_ready` changes only after a clock edge (it is derived from registered occupancy).

## Configuration
- **`WB_ARB_STATS_EN` defined:**
  - Adds outputs `grant_cnt_a`, `grant_cnt_b` (16 bits each): counts of grants, x0 grants included.
  - Adds output `stall_cnt` (16 bits): cycles where `x_valid && !x_ready` for either requester, counted once per cycle.
  - All three saturate at 0xFFFF and reset to 0.
- **Undefined:** these ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- **Single write:** A pushes (rd=5, data=0xDEADBEEF) at edge 1 → `regWrite=1`, `rd=5`, `data=0xDEADBEEF` during cycle after edge 2; `regWrite=0` after edge 3; `busy=0` after edge 3.
- **Tie and alternation:** A and B both hold 3 writes (A: rd 1–3; B: rd 11–13) → `rd` sequence is 1,11,2,12,3,13 on consecutive cycles.
- **Full FIFO back-pressure:** B idle, A pushes every cycle with DEPTH=2 → `a_ready` drops when occupancy hits 2. No write is lost or duplicated: the `rd` sequence equals the accepted sequence. With DEPTH=2, A sustains 1 write/cycle because a pop frees space before the next full check.
- **x0 write:** A pushes rd=0, data=0x1234 → no `regWrite` pulse, and the entry is consumed. With B pending, B is granted next, since `last_grant` is A.
- **Reset mid-operation:** Both FIFOs hold 2 entries and `rst_n` is pulsed low between edges → `regWrite=0` and `rd=0`/`data=0` immediately; `busy=0`. After release, a new A write to rd=7 appears 2 edges later with no stale entries.
- **Stats (`WB_ARB_STATS_EN`):** 4 A grants, 2 B grants, and 3 stalled cycles → `grant_cnt_a=4`, `grant_cnt_b=2`, `stall_cnt=3`. With the counter forced near max, `grant_cnt_a` saturates at 0xFFFF.
